condicionador_botoes: RTL
=========================

# condicionador_botoes

Input-conditioning stage placed directly upstream of the MindFocus game top level. It synchronises and debounces the raw push-button pins and drives the clean `botoes[3:0]` bus consumed by the game. It also emits a single-cycle, single-button press event with its encoded index, rejecting chords (more than one button) and held-over presses.

## Interface

Parameters:
- `N_BOTOES`, default 4: number of buttons. The design is verified only at 4.
- `DEBOUNCE_CICLOS`, default 50000: cycles an input must stay stable before it is accepted. 1 ms at 50 MHz. Minimum 2.

Ports:
- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `botoes_brutos`  in  4  raw, asynchronous button pins, active-high.
- `habilita`  in  1  press events are accepted only while high.
- `botoes`  out  4  debounced, stable button levels; feeds the game `botoes` input.
- `jogada_valida`  out  1  one-cycle pulse on an accepted single-button press.
- `jogada_codigo`  out  2  index of the pressed button; valid while `jogada_valida` is high, held otherwise.
- `db_multiplo`  out  1  high while the FSM is in INVALIDO.
- `db_estado`  out  4  FSM state code, for the hexa7seg debug display.

## Operation

- **Synchronisation.** Each pin passes through a two-flop synchroniser.
- **Debounce, per button.**
  - The counter runs while the synchronised value differs from the stable value.
  - The counter clears whenever the two agree.
  - When the counter reaches `DEBOUNCE_CICLOS-1` while still mismatched, the stable value takes the synchronised value and the counter clears.
  - `botoes` is the vector of stable values.
- **Press FSM.** Registered; codes are 0..3 on `db_estado`.
  - **OCIOSO (0):**
    - `botoes` all zero: stay.
    - Exactly one bit set and `habilita`=1: go to PULSO, latching `jogada_codigo` to that bit index.
    - Exactly one bit set and `habilita`=0: go to SEGURANDO.
    - Two or more bits set: go to INVALIDO.
  - **PULSO (1):**
    - `jogada_valida`=1 for exactly this cycle.
    - Next state is SEGURANDO unconditionally.
  - **SEGURANDO (2):**
    - `botoes` all zero: go to OCIOSO.
    - Any additional bit set: go to INVALIDO.
    - Otherwise stay.
  - **INVALIDO (3):**
    - `db_multiplo`=1.
    - Stays until `botoes` is all zero, then goes to OCIOSO.
- **Boundary rules.**
  - A press held across a rising edge of `habilita` never generates an event; the button must be released first.
  - `habilita` falling while in PULSO does not cancel the pulse.
  - Two buttons becoming stable in the same cycle go to INVALIDO, with no event.
  - The debounce counter width is clog2(`DEBOUNCE_CICLOS`). There is no wrap: the counter is cleared at terminal count.
- **Reset.** Asserting `reset` at any time, including mid-debounce or in PULSO, clears:
  - synchronisers, stable values and counters to 0;
  - the FSM to OCIOSO.

  A button held through reset release is debounced afresh and produces an event if `habilita`=1.

## Timing

- Reset values:
  - `botoes`=0000
  - `jogada_valida`=0
  - `jogada_codigo`=00
  - `db_multiplo`=0
  - `db_estado`=0
- Latency for a clean pin change applied before edge 0 and held:
  - The synchroniser output changes after edge 1.
  - `botoes` changes after edge `DEBOUNCE_CICLOS`+1.
  - `jogada_valida` is high for the cycle after edge `DEBOUNCE_CICLOS`+2.
- A glitch shorter than `DEBOUNCE_CICLOS` cycles after synchronisation never reaches `botoes`.
- The release path has the same latency as the press path.
- Minimum spacing between two accepted events is 2·`DEBOUNCE_CICLOS`+2 cycles: release debounce, then press debounce.
- All outputs are registered; no combinational path from input to output.

## Structure

- **Shared package `mindfocus_pkg`:**
  - FSM state encodings OCIOSO, PULSO, SEGURANDO and INVALIDO;
  - constant `DEBOUNCE_PADRAO`=50000.

  The game FSM and the debug display share the 4-bit state code width.
- **Sub-module `debounce_botao`:** synchroniser, counter and stable register for one pin. It is instantiated `N_BOTOES` times through a generate loop.
- **Top module:** holds the press FSM, one-hot validation and index encoding.

## Test plan

Bench override: `DEBOUNCE_CICLOS`=4.
1. Reset low, then high, with pins at 0000 → all outputs at reset values; `db_estado`=0.
2. `habilita`=1; `botoes_brutos`=0100 held 20 cycles then released → `botoes`=0100 after edge 5; one `jogada_valida` pulse with `jogada_codigo`=10 after edge 6; state 1→2, then back to 0 after the release debounce.
3. Pin 0 toggled for 3-cycle bursts, 10 times → `botoes` stays 0000; no pulse.
4. `botoes_brutos`=0011 in the same cycle → `db_estado`=3 and `db_multiplo`=1; no pulse; back to 0 after release.
5. `habilita`=0, press 1000; raise `habilita` while held; release; press again → no event on the first press; one event, code 11, on the second.
6. `reset` asserted low in PULSO while 0001 is held; then released → outputs clear immediately; a fresh event, code 00, arrives 7 cycles after reset release.

Source files
------------

// File: rtl/mindfocus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mindfocus_pkg: press-FSM state codes and default debounce length.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mindfocus_pkg;

  // 4-bit state code width is shared with the game FSM and hexa7seg display.
  localparam int unsigned W_ESTADO = 4;

  localparam logic [W_ESTADO-1:0] OCIOSO    = 4'd0;
  localparam logic [W_ESTADO-1:0] PULSO     = 4'd1;
  localparam logic [W_ESTADO-1:0] SEGURANDO = 4'd2;
  localparam logic [W_ESTADO-1:0] INVALIDO  = 4'd3;

  // 1 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_PADRAO = 50000;

endpackage
`default_nettype wire

// File: rtl/debounce_botao.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_botao: two-flop synchroniser plus stability counter for one |
// | raw button pin. Rev 1.0                                              |
// +----------------------------------------------------------------------+
module debounce_botao
  import mindfocus_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic pino,
  output logic estavel
);

  localparam int unsigned         W_CONT     = $clog2(DEBOUNCE_CICLOS);
  localparam logic [W_CONT-1:0]   C_TERMINAL = W_CONT'(DEBOUNCE_CICLOS - 1);
  localparam logic [W_CONT-1:0]   C_UM       = W_CONT'(1);

  logic              r_sinc1;
  logic              r_sinc2;
  logic              r_estavel;
  logic [W_CONT-1:0] r_cont;

  // Counter clears at terminal count instead of wrapping, so the accepted
  // level needs DEBOUNCE_CICLOS consecutive mismatched samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sinc1   <= 1'b0;
      r_sinc2   <= 1'b0;
      r_estavel <= 1'b0;
      r_cont    <= '0;
    end else begin
      r_sinc1 <= pino;
      r_sinc2 <= r_sinc1;
      if (r_sinc2 == r_estavel) begin
        r_cont <= '0;
      end else if (r_cont == C_TERMINAL) begin
        r_estavel <= r_sinc2;
        r_cont    <= '0;
      end else begin
        r_cont <= r_cont + C_UM;
      end
    end
  end

  assign estavel = r_estavel;

endmodule
`default_nettype wire

// File: rtl/condicionador_botoes.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | condicionador_botoes: debounced button bus plus single-press event   |
// | generator with chord and held-press rejection. Rev 1.0               |
// +----------------------------------------------------------------------+
module condicionador_botoes
  import mindfocus_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 4,
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_BOTOES-1:0]         botoes_brutos,
  input  logic                        habilita,
  output logic [N_BOTOES-1:0]         botoes,
  output logic                        jogada_valida,
  output logic [$clog2(N_BOTOES)-1:0] jogada_codigo,
  output logic                        db_multiplo,
  output logic [W_ESTADO-1:0]         db_estado
);

  localparam int unsigned         W_COD  = $clog2(N_BOTOES);
  localparam logic [N_BOTOES-1:0] C_UM_B = N_BOTOES'(1);

  logic [N_BOTOES-1:0] w_estaveis;
  logic                w_algum;
  logic                w_unico;
  logic [W_COD-1:0]    w_indice;
  logic [W_ESTADO-1:0] w_prox;

  logic [W_ESTADO-1:0] r_estado;
  logic                r_valida;
  logic [W_COD-1:0]    r_codigo;
  logic                r_multiplo;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_debounce
    debounce_botao #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_debounce (
      .clock  (clock),
      .reset  (reset),
      .pino   (botoes_brutos[i]),
      .estavel(w_estaveis[i])
    );
  end

  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  assign w_algum = |w_estaveis;
  assign w_unico = w_algum && ((w_estaveis & (w_estaveis - C_UM_B)) == '0);

  always_comb begin
    w_indice = '0;
    for (int i = 0; i < N_BOTOES; i++) begin
      if (w_estaveis[i]) w_indice = W_COD'(i);
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: begin
        if (w_unico)      w_prox = habilita ? PULSO : SEGURANDO;
        else if (w_algum) w_prox = INVALIDO;
      end
      PULSO:     w_prox = SEGURANDO;
      SEGURANDO: begin
        if (!w_algum)      w_prox = OCIOSO;
        else if (!w_unico) w_prox = INVALIDO;
      end
      INVALIDO: begin
        if (!w_algum) w_prox = OCIOSO;
      end
      default:   w_prox = OCIOSO;
    endcase
  end

  // Flags are registered from the next state so they align with r_estado.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_valida   <= 1'b0;
      r_codigo   <= '0;
      r_multiplo <= 1'b0;
    end else begin
      r_estado   <= w_prox;
      r_valida   <= (w_prox == PULSO);
      r_multiplo <= (w_prox == INVALIDO);
      if (w_prox == PULSO) r_codigo <= w_indice;
    end
  end

  assign botoes        = w_estaveis;
  assign jogada_valida = r_valida;
  assign jogada_codigo = r_codigo;
  assign db_multiplo   = r_multiplo;
  assign db_estado     = r_estado;

endmodule
`default_nettype wire
